board_line_clear: RTL and testbench
===================================

Name: board_line_clear

Overview:
- Write-side companion to the VGA board reader on the Tetris board RAM. The display scans cell addresses (10*row + col) and reads colour bits [2:0]; this block is the hardware writer on that same interface.
- On a start pulse it scans the 10x20 board RAM for full rows and compacts the board downward. Surviving rows shift down and the top is zero-filled.
- It reports how many lines were cleared, offloading the row-shift loop from the CPU.
- It reaches board RAM through a request/grant port muxed onto the RAM address/wEn alongside the CPU LW/SW path and the display path.

Parameters:
- COLS, 10, cells per row
- ROWS, 20, rows on board
- BASE_ADDR, 0, RAM address of cell (row 0, col 0)
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, 32, RAM data width

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a clear pass; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of pass
- lines_cleared  out  5  number of full rows removed in last pass; valid from done, held until next accepted start
- mem_req  out  1  high whenever busy (block wants RAM)
- mem_grant  in  1  RAM port owned by this block this cycle
- mem_addr  out  ADDR_WIDTH  cell address = BASE_ADDR + row*COLS + col
- mem_wEn  out  1  write strobe; only asserted when mem_grant=1
- mem_dataOut  out  DATA_WIDTH  write data = {zeros, colour[2:0]}
- mem_dataIn  in  DATA_WIDTH  RAM read data, valid 1 cycle after address presented with grant

Behaviour:
- Reset: state IDLE; busy=0, done=0, lines_cleared=0, mem_req=0, mem_wEn=0, mem_addr=0, mem_dataOut=0. A reset mid-pass aborts immediately. Partial RAM contents are left as-is, and no done pulse is issued.
- Cell occupied iff colour bits [2:0] != 0. Row full iff all COLS cells are occupied.
- Registers:
  - src row counter s, starting at ROWS-1 and counting down.
  - dst row counter d, signed or one bit wider, starting at ROWS-1.
  - COLS x 3-bit row buffer.
  - full flag.
  - lines counter.
- States:
  - IDLE: start=1 moves to READ, sets s=d=ROWS-1, col=0, lines=0.
  - READ: each granted cycle presents address (s, col) with col incrementing. Data captured the following cycle goes into buffer[col-1], and the full flag is ANDed. After col COLS-1 is issued, go to CHECK.
  - CHECK (1 cycle): captures the last cell and decides:
    - Row full: lines++, d unchanged.
    - Not full and d != s: go to WRITE.
    - Not full and d == s: d--, no writes.
    - Then, if s == 0, go to FILL; else s-- and return to READ.
  - WRITE: COLS granted cycles write buffer[col] to (d, col) with mem_wEn=1. Then d--, and next state follows the same s rule as CHECK.
  - FILL: while d >= 0, write 0 to every cell of row d over COLS cycles, then d--. When d < 0, go to DONE.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Grant stall: if mem_grant=0, the col counter and state hold, mem_wEn=0, and no read is issued. A read issued in the prior granted cycle is still captured.
- Timing with grant held high: READ+CHECK takes COLS+1 cycles per row. An empty board gives done exactly ROWS*(COLS+1)+1 = 221 cycles after start is sampled, with zero writes.
- start during busy is ignored. start in the same cycle as reset: reset wins.
- lines_cleared saturates naturally: max ROWS = 20 fits in 5 bits.

Test Plan:
- Empty board, grant=1, pulse start → done at cycle 221, lines_cleared=0, mem_wEn never asserted, RAM unchanged.
- Row 19 all colour 3'b001, row 18 = {1,0,2,0,...}, rest 0, then start → lines_cleared=1. Row 19 reads {1,0,2,0,...}, rows 0–18 are all 0, and row 0 was written zero by FILL.
- Rows 17 and 19 full, rows 16 and 18 distinct patterns → lines_cleared=2. Row 19 = old row 18, row 18 = old row 16, rows 0–17 zero.
- All 200 cells = 3'b101 → lines_cleared=20, whole board 0, busy deasserts with a single done pulse.
- Scenario 2 with mem_grant toggling 1,0,1,0… → same final RAM and lines_cleared. No mem_wEn while grant=0, and completion takes roughly twice the cycles.
- Assert reset 50 cycles into a pass → next cycle busy=0, mem_req=0, mem_wEn=0, no done. A start pulse during busy (separate run) has no effect on result or timing.

Source files
------------

// File: rtl/board_line_clear.sv
// Row-compaction pass over the 10x20 Tetris board RAM. It scans bottom-up for full rows,
// shifts surviving rows down, zero-fills the rows freed at the top and counts cleared lines.
module board_line_clear #(
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            lines_cleared,
    output logic                  mem_req,
    input  logic                  mem_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wEn,
    output logic [DATA_WIDTH-1:0] mem_dataOut,
    input  logic [DATA_WIDTH-1:0] mem_dataIn
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = RW + 1;

    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, FILL, DONE} state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        s_q, s_d;
    logic signed [DW-1:0] d_q, d_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 full_q, full_d;
    logic [4:0]           lines_q, lines_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [CW-1:0]        rd_col_q, rd_col_d;
    logic [2:0]           buf_q [COLS];
    logic [2:0]           buf_d [COLS];

    logic          occ, full_now, last_col, advance, addr_en;
    logic [RW-1:0] row_sel;
    int            addr_int;
    logic          unused_hi;

    assign unused_hi = ^mem_dataIn[DATA_WIDTH-1:3];

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        d_d         = d_q;
        col_d       = col_q;
        full_d      = full_q;
        lines_d     = lines_q;
        rd_vld_d    = 1'b0;
        rd_col_d    = col_q;
        buf_d       = buf_q;
        advance     = 1'b0;
        addr_en     = 1'b0;
        row_sel     = s_q;
        mem_wEn     = 1'b0;
        mem_dataOut = '0;

        occ      = |mem_dataIn[2:0];
        full_now = full_q & (~rd_vld_q | occ);
        last_col = (col_q == CW'(COLS - 1));

        // A read granted last cycle lands now, even if the port is stalled this cycle.
        if (rd_vld_q) begin
            buf_d[rd_col_q] = mem_dataIn[2:0];
            full_d          = full_now;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    s_d     = RW'(ROWS - 1);
                    d_d     = DW'(ROWS - 1);
                    col_d   = '0;
                    lines_d = '0;
                    full_d  = 1'b1;
                end
            end
            READ: begin
                addr_en = 1'b1;
                if (mem_grant) begin
                    rd_vld_d = 1'b1;
                    col_d    = last_col ? '0 : col_q + CW'(1);
                    if (last_col) state_d = CHECK;
                end
            end
            CHECK: begin
                if (full_now) begin
                    lines_d = lines_q + 5'd1;
                    advance = 1'b1;
                end else if (d_q != DW'(s_q)) begin
                    state_d = WRITE;
                end else begin
                    d_d     = d_q - DW'(1);
                    advance = 1'b1;
                end
            end
            WRITE: begin
                addr_en = 1'b1;
                row_sel = d_q[RW-1:0];
                if (mem_grant) begin
                    mem_wEn     = 1'b1;
                    mem_dataOut = {{(DATA_WIDTH-3){1'b0}}, buf_q[col_q]};
                    col_d       = last_col ? '0 : col_q + CW'(1);
                    if (last_col) begin
                        d_d     = d_q - DW'(1);
                        advance = 1'b1;
                    end
                end
            end
            FILL: begin
                if (d_q[DW-1]) begin
                    state_d = DONE;
                end else begin
                    addr_en = 1'b1;
                    row_sel = d_q[RW-1:0];
                    if (mem_grant) begin
                        mem_wEn = 1'b1;
                        col_d   = last_col ? '0 : col_q + CW'(1);
                        if (last_col) d_d = d_q - DW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Shared end-of-row step: move to the next source row, or zero-fill once row 0 is done.
        if (advance) begin
            if (s_q == '0) begin
                state_d = FILL;
            end else begin
                s_d     = s_q - RW'(1);
                state_d = READ;
                full_d  = 1'b1;
            end
        end

        addr_int = BASE_ADDR + int'(row_sel) * COLS + int'(col_q);
        mem_addr = addr_en ? ADDR_WIDTH'(addr_int) : '0;
    end

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign mem_req       = busy;
    assign lines_cleared = lines_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            d_q      <= '0;
            col_q    <= '0;
            full_q   <= 1'b0;
            lines_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_col_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            d_q      <= d_d;
            col_q    <= col_d;
            full_q   <= full_d;
            lines_q  <= lines_d;
            rd_vld_q <= rd_vld_d;
            rd_col_q <= rd_col_d;
        end
    end

    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_board_line_clear.sv
// Bench for board_line_clear: board RAM model, directed vector table, randomized boards
// checked against a row-compaction reference model, plus reset/start corner sequences.
module tb_board_line_clear;
    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int NCELL = COLS * ROWS;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  lines_cleared;
    logic        mem_req;
    logic        mem_grant = 1'b1;
    logic [11:0] mem_addr;
    logic        mem_wEn;
    logic [31:0] mem_dataOut;
    logic [31:0] mem_dataIn;

    always #5 clock = ~clock;

    board_line_clear #(
        .COLS(COLS), .ROWS(ROWS), .BASE_ADDR(0), .ADDR_WIDTH(12), .DATA_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .mem_req(mem_req), .mem_grant(mem_grant),
        .mem_addr(mem_addr), .mem_wEn(mem_wEn), .mem_dataOut(mem_dataOut),
        .mem_dataIn(mem_dataIn)
    );

    logic [31:0] ram [256];
    logic [2:0]  brd [NCELL];
    logic [2:0]  exp_brd [NCELL];
    int          exp_lines, exp_writes, exp_cycles;
    logic        load_now = 1'b0;
    logic        clr_mon = 1'b0;
    int          wr_cnt, bad_wen, oob, done_cnt;
    int          grant_mode = 0;
    int          checks = 0;
    int          errors = 0;

    // Board RAM: synchronous read, data one cycle after the address; plus activity monitors.
    always @(posedge clock) begin
        if (load_now) begin
            for (int i = 0; i < NCELL; i++) ram[i] <= {29'd0, brd[i]};
        end else if (mem_wEn && mem_grant) begin
            ram[mem_addr[7:0]] <= mem_dataOut;
        end
        mem_dataIn <= ram[mem_addr[7:0]];
        if (clr_mon) begin
            wr_cnt   <= 0;
            bad_wen  <= 0;
            oob      <= 0;
            done_cnt <= 0;
        end else begin
            if (mem_wEn) wr_cnt <= wr_cnt + 1;
            if (mem_wEn && !mem_grant) bad_wen <= bad_wen + 1;
            if (mem_wEn && mem_addr >= 12'd200) oob <= oob + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge clock) begin
        case (grant_mode)
            1:       mem_grant = ~mem_grant;
            2:       mem_grant = ($urandom_range(0, 3) != 0);
            default: mem_grant = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input int kind);
        for (int i = 0; i < NCELL; i++) brd[i] = 3'd0;
        case (kind)
            0: ;
            1: for (int c = 0; c < COLS; c++) begin
                brd[19*COLS+c] = 3'd1;
                brd[18*COLS+c] = (c % 4 == 0) ? 3'd1 : ((c % 4 == 2) ? 3'd2 : 3'd0);
            end
            2: for (int c = 0; c < COLS; c++) begin
                brd[19*COLS+c] = 3'd4;
                brd[17*COLS+c] = 3'd7;
                brd[18*COLS+c] = 3'(c % 8);
                brd[16*COLS+c] = (c % 2 == 1) ? 3'(c % 7 + 1) : 3'd0;
            end
            3: for (int i = 0; i < NCELL; i++) brd[i] = 3'b101;
            default: for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 2) == 0) begin
                    for (int c = 0; c < COLS; c++) brd[r*COLS+c] = 3'($urandom_range(1, 7));
                end else begin
                    for (int c = 0; c < COLS; c++) brd[r*COLS+c] = 3'($urandom_range(0, 7));
                end
            end
        endcase
    endtask

    // Reference: drop full rows, stack survivors at the bottom in order, zeros above.
    task automatic model();
        int surv [$];
        int nl, nw;
        bit full;
        nl = 0;
        nw = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (brd[r*COLS+c] == 3'd0) full = 1'b0;
            if (full) nl++;
            else begin
                surv.push_back(r);
                if (nl > 0) nw++;
            end
        end
        for (int i = 0; i < NCELL; i++) exp_brd[i] = 3'd0;
        for (int j = 0; j < surv.size(); j++)
            for (int c = 0; c < COLS; c++)
                exp_brd[(ROWS-1-j)*COLS+c] = brd[surv[j]*COLS+c];
        exp_lines  = nl;
        exp_writes = COLS * (nw + nl);
        exp_cycles = ROWS * (COLS + 1) + COLS * (nw + nl) + 1;
    endtask

    task automatic load_board();
        load_now = 1'b1;
        clr_mon  = 1'b1;
        @(posedge clock); #1;
        load_now = 1'b0;
        clr_mon  = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int gmode, input int extra_at, output int cyc);
        bit seen;
        grant_mode = gmode;
        load_board();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(posedge clock); #1;
            cyc++;
            start = (cyc == extra_at);
            seen  = done;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, seen, 1'b1);
        chk({tag, " busy_at_done"}, busy, 1'b0);
    endtask

    task automatic post_checks(input string tag);
        int nbad, first;
        repeat (3) @(posedge clock);
        #1;
        chk({tag, " done_dropped"}, done, 1'b0);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " lines_model"}, lines_cleared, exp_lines);
        chk({tag, " writes"}, wr_cnt, exp_writes);
        chk({tag, " wen_no_grant"}, bad_wen, 0);
        chk({tag, " addr_range"}, oob, 0);
        nbad  = 0;
        first = 0;
        for (int i = 0; i < NCELL; i++) begin
            if (ram[i] !== {29'd0, exp_brd[i]}) begin
                if (nbad == 0) first = i;
                nbad++;
            end
        end
        if (nbad != 0)
            $display("note %s: first differing cell %0d holds %0d, model %0d", tag, first, ram[first], exp_brd[first]);
        chk({tag, " bad_cells"}, nbad, 0);
    endtask

    typedef struct {
        int kind;
        int gmode;
        int exp_lines;
        int exp_cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cyc, gm;
        string tag;

        vecs[0] = '{0, 0, 0, 221};
        vecs[1] = '{1, 0, 1, 421};
        vecs[2] = '{2, 0, 2, 421};
        vecs[3] = '{3, 0, 20, 421};
        vecs[4] = '{1, 1, 1, -1};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst lines", lines_cleared, 5'd0);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_wEn", mem_wEn, 1'b0);
        chk("rst mem_addr", mem_addr, 12'd0);
        chk("rst mem_dataOut", mem_dataOut, 32'd0);

        // start coinciding with reset must not launch a pass
        start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;
        chk("start_with_reset busy", busy, 1'b0);

        for (int v = 0; v < 5; v++) begin
            tag = $sformatf("vec%0d", v);
            build(vecs[v].kind);
            model();
            run_pass(tag, vecs[v].gmode, -1, cyc);
            chk({tag, " lines"}, lines_cleared, vecs[v].exp_lines);
            if (vecs[v].exp_cyc >= 0) chk({tag, " cycles"}, cyc, vecs[v].exp_cyc);
            else chk({tag, " cycles_stalled"}, (cyc >= 780 && cyc <= 880), 1'b1);
            post_checks(tag);
        end

        for (int n = 0; n < 6; n++) begin
            tag = $sformatf("rand%0d", n);
            gm  = ($urandom_range(0, 1) == 1) ? 2 : 0;
            build(4);
            model();
            run_pass(tag, gm, -1, cyc);
            if (gm == 0) chk({tag, " cycles"}, cyc, exp_cycles);
            post_checks(tag);
        end

        // a second start while busy must change neither result nor timing
        build(1);
        model();
        run_pass("start_busy", 0, 30, cyc);
        chk("start_busy lines", lines_cleared, 5'd1);
        chk("start_busy cycles", cyc, 421);
        post_checks("start_busy");

        // reset 50 cycles into a pass aborts it with no done pulse
        build(3);
        grant_mode = 0;
        load_board();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (49) @(posedge clock);
        #1;
        chk("abort busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort busy", busy, 1'b0);
        chk("abort mem_req", mem_req, 1'b0);
        chk("abort mem_wEn", mem_wEn, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort lines", lines_cleared, 5'd0);
        reset = 1'b0;
        repeat (300) @(posedge clock);
        #1;
        chk("abort no_done", done_cnt, 0);
        chk("abort stays_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
